// File: rtl/execute_stage_md_pkg.sv
// Shared encodings for the execute stage: ALU opcodes, operand/forward selects,
// RV32M funct3 codes and the mul/div sequencer state.
package execute_stage_md_pkg;

   localparam int XLEN_DEF = 32;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLL  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_SLT  = 4'd8;
   localparam logic [3:0] ALU_SLTU = 4'd9;
   localparam logic [3:0] ALU_BEQ  = 4'd10;
   localparam logic [3:0] ALU_BNE  = 4'd11;
   localparam logic [3:0] ALU_BLT  = 4'd12;
   localparam logic [3:0] ALU_BGE  = 4'd13;
   localparam logic [3:0] ALU_BLTU = 4'd14;
   localparam logic [3:0] ALU_BGEU = 4'd15;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_ZERO0 = 2'b01;
   localparam logic [1:0] SRCA_ZERO1 = 2'b10;
   localparam logic [1:0] SRCA_REG   = 2'b11;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;
   localparam logic [1:0] SRCB_ZERO = 2'b11;

   localparam logic [1:0] FWD_RF     = 2'b00;
   localparam logic [1:0] FWD_WB     = 2'b01;
   localparam logic [1:0] FWD_MEM    = 2'b10;
   localparam logic [1:0] FWD_RF_ALT = 2'b11;

   localparam logic [2:0] MD_MUL    = 3'd0;
   localparam logic [2:0] MD_MULH   = 3'd1;
   localparam logic [2:0] MD_MULHSU = 3'd2;
   localparam logic [2:0] MD_MULHU  = 3'd3;
   localparam logic [2:0] MD_DIV    = 3'd4;
   localparam logic [2:0] MD_DIVU   = 3'd5;
   localparam logic [2:0] MD_REM    = 3'd6;
   localparam logic [2:0] MD_REMU   = 3'd7;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_RUN  = 2'd1,
      MD_DONE = 2'd2
   } md_state_t;

   function automatic logic is_div_op(input logic [2:0] op);
      return op[2];
   endfunction

endpackage

// File: rtl/execute_stage_md_if.sv
// E-stage inputs and E/M register outputs bundled as one bus; md_state is a
// read-only debug view of the mul/div sequencer.
import execute_stage_md_pkg::*;

interface execute_stage_md_if #(parameter int XLEN = XLEN_DEF);
   logic            validE;
   logic            killE;
   logic            flushM;
   logic            RegWriteE;
   logic            MemWriteE;
   logic            MemtoRegE;
   logic            PCBranchE;
   logic [2:0]      strCtrlE;
   logic [3:0]      ALUopE;
   logic [1:0]      SrcASelE;
   logic [1:0]      SrcBSelE;
   logic            MulDivE;
   logic [2:0]      MulDivOpE;
   logic [XLEN-1:0] immE;
   logic [XLEN-1:0] PCE;
   logic [XLEN-1:0] r1E;
   logic [XLEN-1:0] r2E;
   logic [4:0]      rdE;
   logic [1:0]      ForwardAE;
   logic [1:0]      ForwardBE;
   logic [XLEN-1:0] ResultW;

   logic            busyE;
   logic            PCsrcE;
   logic [XLEN-1:0] PCplusImmE;
   logic            RegWriteM;
   logic            MemWriteM;
   logic            MemtoRegM;
   logic [2:0]      strCtrlM;
   logic [4:0]      rdM;
   logic [XLEN-1:0] ALUoutM;
   logic [XLEN-1:0] r2M;
   md_state_t       md_state;

   // Handshake: while busyE is 1 the upstream stages hold every E input stable;
   // an instruction is consumed on the first edge where busyE is 0 and it is live.
   modport master (
      output validE, killE, flushM, RegWriteE, MemWriteE, MemtoRegE, PCBranchE,
             strCtrlE, ALUopE, SrcASelE, SrcBSelE, MulDivE, MulDivOpE, immE, PCE,
             r1E, r2E, rdE, ForwardAE, ForwardBE, ResultW,
      input  busyE, PCsrcE, PCplusImmE, RegWriteM, MemWriteM, MemtoRegM, strCtrlM,
             rdM, ALUoutM, r2M, md_state
   );

   modport slave (
      input  validE, killE, flushM, RegWriteE, MemWriteE, MemtoRegE, PCBranchE,
             strCtrlE, ALUopE, SrcASelE, SrcBSelE, MulDivE, MulDivOpE, immE, PCE,
             r1E, r2E, rdE, ForwardAE, ForwardBE, ResultW,
      output busyE, PCsrcE, PCplusImmE, RegWriteM, MemWriteM, MemtoRegM, strCtrlM,
             rdM, ALUoutM, r2M, md_state
   );
endinterface

// File: rtl/alu.sv
// Single-cycle integer ALU; branch opcodes also raise the compare flag.
module alu
   import execute_stage_md_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [3:0]      op,
   output logic [XLEN-1:0] y,
   output logic            branch
);
   localparam int SW = $clog2(XLEN);

   logic eq, lt, ltu;
   logic [SW-1:0] sh;

   always_comb begin
      eq  = (a == b);
      lt  = ($signed(a) < $signed(b));
      ltu = (a < b);
      sh  = b[SW-1:0];
      y   = a - b;
      branch = 1'b0;
      case (op)
         ALU_ADD:  y = a + b;
         ALU_SUB:  y = a - b;
         ALU_AND:  y = a & b;
         ALU_OR:   y = a | b;
         ALU_XOR:  y = a ^ b;
         ALU_SLL:  y = a << sh;
         ALU_SRL:  y = a >> sh;
         ALU_SRA:  y = $unsigned($signed(a) >>> sh);
         ALU_SLT:  y = {{(XLEN-1){1'b0}}, lt};
         ALU_SLTU: y = {{(XLEN-1){1'b0}}, ltu};
         ALU_BEQ:  branch = eq;
         ALU_BNE:  branch = ~eq;
         ALU_BLT:  branch = lt;
         ALU_BGE:  branch = ~lt;
         ALU_BLTU: branch = ltu;
         ALU_BGEU: branch = ~ltu;
         default:  y = a - b;
      endcase
   end
endmodule

// File: rtl/execute_stage_md_muldiv_iter.sv
// Iterative RV32M unit: shift-add multiply / restoring divide on magnitudes,
// one bit per cycle, with the sign fixed up when the result is presented.
module muldiv_iter
   import execute_stage_md_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            kill,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output md_state_t       state
);
   localparam int CW = $clog2(XLEN);

   md_state_t       state_n;
   logic [CW-1:0]   cnt;
   logic [2:0]      op_q;
   logic [XLEN-1:0] hi, lo, opnd, a_raw;
   logic            neg_q, neg_r, div0;

   logic            a_signed, b_signed;
   logic [XLEN-1:0] a_mag, b_mag;
   logic [XLEN:0]   mul_sum, div_rs, div_trial;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0] quot, rem;

   always_comb begin
      a_signed = 1'b0;
      b_signed = 1'b0;
      case (op)
         MD_MULH, MD_DIV, MD_REM: begin
            a_signed = a[XLEN-1];
            b_signed = b[XLEN-1];
         end
         MD_MULHSU: a_signed = a[XLEN-1];
         default: ;
      endcase
      a_mag = a_signed ? -a : a;
      b_mag = b_signed ? -b : b;
   end

   // hi is the running partial product / partial remainder, lo the multiplier / quotient.
   always_comb begin
      mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
      div_rs    = {hi, lo[XLEN-1]};
      div_trial = div_rs - {1'b0, opnd};
   end

   always_comb begin
      prod = neg_q ? -{hi, lo} : {hi, lo};
      quot = div0 ? '1 : (neg_q ? -lo : lo);
      rem  = div0 ? a_raw : (neg_r ? -hi : hi);
      case (op_q)
         MD_MUL:                       result = prod[XLEN-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU: result = prod[2*XLEN-1:XLEN];
         MD_DIV, MD_DIVU:              result = quot;
         default:                      result = rem;
      endcase
   end

   always_comb begin
      state_n = state;
      busy    = 1'b0;
      done    = 1'b0;
      case (state)
         MD_IDLE: begin
            busy = start;
            if (start) state_n = MD_RUN;
         end
         MD_RUN: begin
            busy = 1'b1;
            if (kill) state_n = MD_IDLE;
            else if (cnt == CW'(XLEN-1)) state_n = MD_DONE;
         end
         MD_DONE: begin
            done    = ~kill;
            state_n = MD_IDLE;
         end
         default: state_n = MD_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= MD_IDLE;
      else     state <= state_n;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         op_q  <= '0;
         hi    <= '0;
         lo    <= '0;
         opnd  <= '0;
         a_raw <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         div0  <= 1'b0;
      end else if (state == MD_IDLE && start) begin
         cnt   <= '0;
         op_q  <= op;
         hi    <= '0;
         a_raw <= a;
         div0  <= is_div_op(op) && (b == '0);
         neg_q <= a_signed ^ b_signed;
         neg_r <= a_signed;
         if (is_div_op(op)) begin
            opnd <= b_mag;
            lo   <= a_mag;
         end else begin
            opnd <= a_mag;
            lo   <= b_mag;
         end
      end else if (state == MD_RUN) begin
         cnt <= cnt + 1'b1;
         if (is_div_op(op_q)) begin
            if (!div_trial[XLEN]) begin
               hi <= div_trial[XLEN-1:0];
               lo <= {lo[XLEN-2:0], 1'b1};
            end else begin
               hi <= div_rs[XLEN-1:0];
               lo <= {lo[XLEN-2:0], 1'b0};
            end
         end else begin
            hi <= mul_sum[XLEN:1];
            lo <= {mul_sum[0], lo[XLEN-1:1]};
         end
      end
   end
endmodule

// File: rtl/execute_stage_md.sv
// Execute stage with operand forwarding, kill/flush qualification, an optional
// iterative mul/div unit and the E->M pipeline register.
module execute_stage_md
   import execute_stage_md_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter bit MD_EN = 1'b1
) (
   input logic clk,
   input logic rst,
   execute_stage_md_if.slave bus
);
   logic            live_e, md_sel, md_start, md_busy, md_done, bubble;
   logic [XLEN-1:0] fwd_a, fwd_b, src_a, src_b, alu_y, md_result;
   logic            alu_br;
   md_state_t       md_state;

   logic            reg_write_m, mem_write_m, mem_to_reg_m;
   logic [2:0]      str_ctrl_m;
   logic [4:0]      rd_m;
   logic [XLEN-1:0] alu_out_m, r2_m;

   assign live_e = bus.validE & ~bus.killE;

   always_comb begin
      case (bus.ForwardAE)
         FWD_WB:  fwd_a = bus.ResultW;
         FWD_MEM: fwd_a = alu_out_m;
         default: fwd_a = bus.r1E;
      endcase
      case (bus.ForwardBE)
         FWD_WB:  fwd_b = bus.ResultW;
         FWD_MEM: fwd_b = alu_out_m;
         default: fwd_b = bus.r2E;
      endcase
      case (bus.SrcASelE)
         SRCA_PC:  src_a = bus.PCE;
         SRCA_REG: src_a = fwd_a;
         default:  src_a = '0;
      endcase
      case (bus.SrcBSelE)
         SRCB_REG:  src_b = fwd_b;
         SRCB_IMM:  src_b = bus.immE;
         SRCB_FOUR: src_b = XLEN'(4);
         default:   src_b = '0;
      endcase
   end

   alu #(.XLEN(XLEN)) u_alu (
      .a      (src_a),
      .b      (src_b),
      .op     (bus.ALUopE),
      .y      (alu_y),
      .branch (alu_br)
   );

   assign bus.PCsrcE     = alu_br & bus.PCBranchE & live_e;
   assign bus.PCplusImmE = bus.PCE + bus.immE;

   // Reset is folded into start so a held-live mul/div cannot re-raise busy during rst.
   assign md_sel   = MD_EN & bus.MulDivE;
   assign md_start = live_e & md_sel & ~rst;

   generate
      if (MD_EN) begin : g_md
         muldiv_iter #(.XLEN(XLEN)) u_md (
            .clk    (clk),
            .rst    (rst),
            .start  (md_start),
            .op     (bus.MulDivOpE),
            .a      (fwd_a),
            .b      (fwd_b),
            .kill   (bus.killE),
            .busy   (md_busy),
            .done   (md_done),
            .result (md_result),
            .state  (md_state)
         );
      end else begin : g_no_md
         assign md_busy   = 1'b0;
         assign md_done   = 1'b0;
         assign md_result = '0;
         assign md_state  = MD_IDLE;
      end
   endgenerate

   assign bus.busyE    = md_busy;
   assign bus.md_state = md_state;

   // A mul/div instruction only reaches M on its completion cycle; every other
   // cycle it occupies E shows up in M as a bubble.
   assign bubble = rst | bus.flushM | ~live_e | md_busy | (md_sel & ~md_done);

   always_ff @(posedge clk) begin
      if (bubble) begin
         reg_write_m  <= 1'b0;
         mem_write_m  <= 1'b0;
         mem_to_reg_m <= 1'b0;
         str_ctrl_m   <= '0;
         rd_m         <= '0;
         alu_out_m    <= '0;
         r2_m         <= '0;
      end else begin
         reg_write_m  <= bus.RegWriteE;
         mem_write_m  <= bus.MemWriteE;
         mem_to_reg_m <= bus.MemtoRegE;
         str_ctrl_m   <= bus.strCtrlE;
         rd_m         <= bus.rdE;
         alu_out_m    <= md_sel ? md_result : alu_y;
         r2_m         <= fwd_b;
      end
   end

   assign bus.RegWriteM = reg_write_m;
   assign bus.MemWriteM = mem_write_m;
   assign bus.MemtoRegM = mem_to_reg_m;
   assign bus.strCtrlM  = str_ctrl_m;
   assign bus.rdM       = rd_m;
   assign bus.ALUoutM   = alu_out_m;
   assign bus.r2M       = r2_m;
endmodule

// File: tb/tb_execute_stage_md.sv
// Directed + randomized bench for execute_stage_md against an arithmetic model
// of forwarding, ALU results and RV32M semantics.
module tb_execute_stage_md;
   import execute_stage_md_pkg::*;

   localparam int XLEN = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   execute_stage_md_if #(.XLEN(XLEN)) bus ();

   execute_stage_md #(.XLEN(XLEN), .MD_EN(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;
   logic [XLEN-1:0] exp_q[$];
   logic [XLEN-1:0] m_alu;

   task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   function automatic logic [XLEN-1:0] pick_fwd(input logic [1:0] f, input logic [XLEN-1:0] rv,
                                                 input logic [XLEN-1:0] wb, input logic [XLEN-1:0] mem);
      if (f == 2'b01) return wb;
      if (f == 2'b10) return mem;
      return rv;
   endfunction

   function automatic logic [XLEN-1:0] alu_model(input logic [3:0] op, input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
      int sh;
      sh = int'(b % 32);
      case (op)
         ALU_ADD:  return a + b;
         ALU_SUB:  return a - b;
         ALU_AND:  return a & b;
         ALU_OR:   return a | b;
         ALU_XOR:  return a ^ b;
         ALU_SLL:  return a << sh;
         ALU_SRL:  return a >> sh;
         ALU_SRA:  return $unsigned($signed(a) >>> sh);
         ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
         default:  return a - b;
      endcase
   endfunction

   function automatic logic [XLEN-1:0] md_model(input logic [2:0] op, input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
      longint sa, sb, ua, ub, q;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      case (op)
         MD_MUL:    begin p = 64'(ua * ub); return p[31:0];  end
         MD_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
         MD_MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
         MD_MULHU:  begin p = 64'(ua * ub); return p[63:32]; end
         MD_DIV: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            q = sa / sb;
            return q[31:0];
         end
         MD_DIVU: begin
            if (b == 0) return 32'hFFFF_FFFF;
            return a / b;
         end
         MD_REM: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            q = sa % sb;
            return q[31:0];
         end
         default: begin
            if (b == 0) return a;
            return a % b;
         end
      endcase
   endfunction

   // ---------------- drivers ----------------
   task automatic clear_e();
      bus.validE = 1'b0; bus.killE = 1'b0; bus.flushM = 1'b0;
      bus.RegWriteE = 1'b0; bus.MemWriteE = 1'b0; bus.MemtoRegE = 1'b0; bus.PCBranchE = 1'b0;
      bus.strCtrlE = 3'd0; bus.ALUopE = 4'd0; bus.SrcASelE = 2'd0; bus.SrcBSelE = 2'd0;
      bus.MulDivE = 1'b0; bus.MulDivOpE = 3'd0; bus.immE = '0; bus.PCE = '0;
      bus.r1E = '0; bus.r2E = '0; bus.rdE = '0; bus.ForwardAE = 2'd0; bus.ForwardBE = 2'd0;
      bus.ResultW = '0;
   endtask

   task automatic drive_alu(input logic [3:0] op, input logic [XLEN-1:0] r1, input logic [XLEN-1:0] r2,
                            input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] fa,
                            input logic [1:0] fb, input logic [4:0] rd, input logic rw, input logic mw);
      clear_e();
      bus.validE = 1'b1; bus.ALUopE = op; bus.r1E = r1; bus.r2E = r2;
      bus.SrcASelE = sa; bus.SrcBSelE = sb; bus.ForwardAE = fa; bus.ForwardBE = fb;
      bus.rdE = rd; bus.RegWriteE = rw; bus.MemWriteE = mw; bus.strCtrlE = 3'b010;
   endtask

   task automatic drive_md(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      clear_e();
      bus.validE = 1'b1; bus.MulDivE = 1'b1; bus.MulDivOpE = op;
      bus.r1E = a; bus.r2E = b; bus.RegWriteE = 1'b1; bus.rdE = 5'd9;
      bus.SrcASelE = SRCA_REG; bus.SrcBSelE = SRCB_REG;
   endtask

   // Issue one mul/div op, measure busy length and M-stage result timing.
   task automatic run_md(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input bit flush_at_done);
      int n;
      bit bad;
      logic [XLEN-1:0] exp;
      drive_md(op, a, b);
      exp = flush_at_done ? '0 : md_model(op, a, b);
      exp_q.push_back(exp);
      n = 0;
      bad = 0;
      #1;
      while (bus.busyE === 1'b1 && n < 100) begin
         if (n > 0 && (bus.RegWriteM !== 1'b0 || bus.ALUoutM !== '0)) bad = 1;
         n++;
         step();
      end
      check("md_busy_cycles", XLEN'(n), XLEN'(XLEN + 1));
      check("md_m_bubble", XLEN'(bad), '0);
      check("md_state_done", XLEN'(bus.md_state), XLEN'(MD_DONE));
      if (flush_at_done) bus.flushM = 1'b1;
      step();
      bus.flushM = 1'b0;
      check("md_result", bus.ALUoutM, exp_q.pop_front());
      check("md_regwrite", XLEN'(bus.RegWriteM), flush_at_done ? '0 : XLEN'(1));
      check("md_state_idle", XLEN'(bus.md_state), XLEN'(MD_IDLE));
      bus.validE = 1'b0;
      bus.MulDivE = 1'b0;
      m_alu = exp;
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      logic [XLEN-1:0] exp, exp_r2, fa_v, fb_v, sa_v, sb_v;
      logic [3:0] op;
      logic [1:0] sa, sb, fa, fb;
      logic [XLEN-1:0] r1, r2, imm, pc, rw_v, a, b;
      bit v, k, f, rwb;

      rst = 1'b1;
      clear_e();
      repeat (2) step();
      check("rst_regwrite", XLEN'(bus.RegWriteM), '0);
      check("rst_memwrite", XLEN'(bus.MemWriteM), '0);
      check("rst_aluout", bus.ALUoutM, '0);
      check("rst_r2m", bus.r2M, '0);
      check("rst_busy", XLEN'(bus.busyE), '0);
      check("rst_state", XLEN'(bus.md_state), XLEN'(MD_IDLE));
      rst = 1'b0;
      m_alu = '0;

      // plain ADD
      drive_alu(ALU_ADD, 32'd5, 32'd7, SRCA_REG, SRCB_REG, FWD_RF, FWD_RF, 5'd3, 1'b1, 1'b0);
      #1;
      check("add_busy", XLEN'(bus.busyE), '0);
      step();
      check("add_result", bus.ALUoutM, 32'd12);
      check("add_regwrite", XLEN'(bus.RegWriteM), XLEN'(1));
      check("add_rd", XLEN'(bus.rdM), XLEN'(3));
      check("add_strctrl", XLEN'(bus.strCtrlM), XLEN'(3'b010));

      // forwarding from M and W
      drive_alu(ALU_ADD, 32'h100, 32'h0, SRCA_REG, SRCB_ZERO, FWD_RF, FWD_RF, 5'd4, 1'b1, 1'b0);
      step();
      check("fwd_prime", bus.ALUoutM, 32'h100);
      drive_alu(ALU_ADD, 32'hDEAD, 32'hBEEF, SRCA_REG, SRCB_REG, FWD_MEM, FWD_WB, 5'd0, 1'b0, 1'b1);
      bus.ResultW = 32'd3;
      step();
      check("fwd_result", bus.ALUoutM, 32'h103);
      check("fwd_store_data", bus.r2M, 32'd3);
      check("fwd_memwrite", XLEN'(bus.MemWriteM), XLEN'(1));
      m_alu = 32'h103;

      // randomized ALU traffic with random forwarding, selects, valid/kill/flush
      for (int i = 0; i < 24; i++) begin
         op = 4'($urandom_range(0, 9));
         r1 = $urandom; r2 = $urandom; imm = $urandom; pc = $urandom; rw_v = $urandom;
         sa = 2'($urandom_range(0, 3)); sb = 2'($urandom_range(0, 3));
         fa = 2'($urandom_range(0, 3)); fb = 2'($urandom_range(0, 3));
         v = ($urandom_range(0, 3) != 0); k = ($urandom_range(0, 7) == 0); f = ($urandom_range(0, 7) == 0);
         rwb = $urandom_range(0, 1);
         drive_alu(op, r1, r2, sa, sb, fa, fb, 5'($urandom_range(1, 31)), rwb, 1'b0);
         bus.immE = imm; bus.PCE = pc; bus.ResultW = rw_v;
         bus.validE = v; bus.killE = k; bus.flushM = f;
         fa_v = pick_fwd(fa, r1, rw_v, m_alu);
         fb_v = pick_fwd(fb, r2, rw_v, m_alu);
         sa_v = (sa == 2'b00) ? pc : ((sa == 2'b11) ? fa_v : '0);
         sb_v = (sb == 2'b00) ? fb_v : ((sb == 2'b01) ? imm : ((sb == 2'b10) ? 32'd4 : '0));
         if (!v || k || f) begin
            exp = '0; exp_r2 = '0;
         end else begin
            exp = alu_model(op, sa_v, sb_v); exp_r2 = fb_v;
         end
         exp_q.push_back(exp);
         step();
         check("rnd_aluout", bus.ALUoutM, exp_q.pop_front());
         check("rnd_r2m", bus.r2M, exp_r2);
         check("rnd_regwrite", XLEN'(bus.RegWriteM), (!v || k || f) ? '0 : XLEN'(rwb));
         m_alu = exp;
      end
      clear_e();

      // directed RV32M corner cases
      run_md(MD_MUL,   32'hFFFF_FFFF, 32'd2, 1'b0);
      run_md(MD_MULHU, 32'hFFFF_FFFF, 32'd2, 1'b0);
      run_md(MD_MULH,  32'hFFFF_FFFF, 32'd2, 1'b0);
      run_md(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_md(MD_REM,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_md(MD_DIVU,  32'd7, 32'd0, 1'b0);
      run_md(MD_REMU,  32'd7, 32'd0, 1'b0);
      run_md(MD_DIV,   32'hFFFF_FFF9, 32'd0, 1'b0);
      run_md(MD_REM,   32'hFFFF_FFF9, 32'd2, 1'b0);

      // randomized RV32M
      for (int i = 0; i < 6; i++) begin
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
         run_md(3'($urandom_range(0, 7)), a, b, 1'b0);
      end

      // flush during completion: bubble wins
      run_md(MD_MULHSU, 32'h8000_0001, 32'hFFFF_FFFF, 1'b1);

      // kill in RUN
      drive_md(MD_DIV, 32'd100, 32'd7);
      #1;
      check("kill_busy_start", XLEN'(bus.busyE), XLEN'(1));
      repeat (11) step();
      check("kill_state_run", XLEN'(bus.md_state), XLEN'(MD_RUN));
      bus.killE = 1'b1;
      step();
      check("kill_busy_drop", XLEN'(bus.busyE), '0);
      check("kill_regwrite", XLEN'(bus.RegWriteM), '0);
      check("kill_state", XLEN'(bus.md_state), XLEN'(MD_IDLE));
      drive_alu(ALU_SUB, 32'd50, 32'd8, SRCA_REG, SRCB_REG, FWD_RF, FWD_RF, 5'd6, 1'b1, 1'b0);
      step();
      check("kill_next_alu", bus.ALUoutM, 32'd42);
      check("kill_next_rw", XLEN'(bus.RegWriteM), XLEN'(1));

      // branch resolution and PC+imm
      drive_alu(ALU_BEQ, 32'h55, 32'h55, SRCA_REG, SRCB_REG, FWD_RF, FWD_RF, 5'd0, 1'b0, 1'b0);
      bus.PCBranchE = 1'b1; bus.PCE = 32'h1000; bus.immE = 32'h20;
      #1;
      check("beq_taken", XLEN'(bus.PCsrcE), XLEN'(1));
      check("pc_plus_imm", bus.PCplusImmE, 32'h1020);
      bus.validE = 1'b0;
      #1;
      check("beq_invalid", XLEN'(bus.PCsrcE), '0);
      bus.validE = 1'b1; bus.r2E = 32'h56;
      #1;
      check("beq_not_equal", XLEN'(bus.PCsrcE), '0);
      bus.ALUopE = ALU_BNE;
      #1;
      check("bne_taken", XLEN'(bus.PCsrcE), XLEN'(1));
      bus.killE = 1'b1;
      #1;
      check("bne_killed", XLEN'(bus.PCsrcE), '0);
      bus.PCE = 32'hFFFF_FFF0;
      #1;
      check("pc_plus_imm_wrap", bus.PCplusImmE, 32'h10);
      clear_e();

      // reset in the middle of a divide
      drive_alu(ALU_ADD, 32'd9, 32'd1, SRCA_REG, SRCB_REG, FWD_RF, FWD_RF, 5'd2, 1'b1, 1'b0);
      step();
      drive_md(MD_DIVU, 32'd1000, 32'd3);
      repeat (6) step();
      rst = 1'b1;
      step();
      check("rstmid_busy", XLEN'(bus.busyE), '0);
      check("rstmid_regwrite", XLEN'(bus.RegWriteM), '0);
      check("rstmid_aluout", bus.ALUoutM, '0);
      check("rstmid_rd", XLEN'(bus.rdM), '0);
      check("rstmid_state", XLEN'(bus.md_state), XLEN'(MD_IDLE));
      rst = 1'b0;
      clear_e();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
